// File: rtl/axi_rt_pkg.sv
// Shared types for the AXI real-time unit: latency width and timestamp type.
package axi_rt_pkg;

    localparam int unsigned RtLatWidth          = 32;
    localparam int unsigned RtBytesWidthDefault = 32;

    typedef logic [RtLatWidth-1:0] rt_lat_t;

endpackage

// File: rtl/fifo_v3.sv
// Generic in-order FIFO with occupancy count; optional fall-through read path.
// Latency: 1 cycle push-to-visible (0 with FALL_THROUGH). Backpressure: full_o; a push while full is taken only alongside a pop.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    localparam int unsigned FifoDepth = (DEPTH > 0) ? DEPTH : 1;

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic                  do_push, do_pop, ft_bypass;
    dtype                  mem_q [FifoDepth];

    function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
        return (p == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o    = (cnt_q == (ADDR_DEPTH+1)'(FifoDepth));
    assign empty_o   = (cnt_q == '0) && !(FALL_THROUGH && push_i);
    assign usage_o   = cnt_q[ADDR_DEPTH-1:0];
    assign data_o    = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rd_ptr_q];

    // A fall-through push+pop on an empty FIFO passes straight through.
    assign ft_bypass = FALL_THROUGH && (cnt_q == '0) && push_i && pop_i;
    assign do_pop    = pop_i && (cnt_q != '0);
    assign do_push   = push_i && (!full_o || do_pop) && !ft_bypass;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ax_rt_unit_rsp_tracker.sv
// Tracks outstanding AXI transactions: pending count, bytes in flight, sticky error, worst latency (AXI_RT_RSP_LATENCY_EN).
// Latency: counters update 1 cycle after push/pop; limit_reached_o is combinational from max_pending_i.
// Backpressure: none applied; limit_reached_o is advisory, pushes into full storage are dropped and flagged.
module ax_rt_unit_rsp_tracker
    import axi_rt_pkg::*;
#(
    parameter int unsigned MaxPending = 32'd8,
    parameter int unsigned BytesWidth = 32'd32,
    parameter type         ax_bytes_t = logic,
    parameter type         pend_t     = logic [$clog2(MaxPending+1)-1:0]
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  ax_bytes_t             ax_bytes_i,
    input  logic                  ax_happening_i,
    input  logic                  rsp_done_i,
    input  pend_t                 max_pending_i,
    input  logic                  clear_i,
    output pend_t                 pending_o,
    output logic [BytesWidth-1:0] bytes_in_flight_o,
    output logic                  limit_reached_o,
    output logic                  error_o,
    output logic [RtLatWidth-1:0] max_latency_o
);

    localparam int unsigned AddrW = (MaxPending > 1) ? $clog2(MaxPending) : 1;

    typedef logic [BytesWidth-1:0] bytes_t;

`ifdef AXI_RT_RSP_LATENCY_EN
    typedef struct packed {
        rt_lat_t stamp;
        bytes_t  bytes;
    } entry_t;
`else
    typedef struct packed {
        bytes_t  bytes;
    } entry_t;
`endif

    logic             push_req, pop_req, push, pop;
    logic             full, empty;
    logic [AddrW-1:0] usage;
    entry_t           wr_entry, rd_entry;
    bytes_t           bytes_q, bytes_d;
    logic             err_q, err_d;
    logic [BytesWidth+1:0] bytes_sum;

    assign push_req = enable_i && ax_happening_i && !clear_i;
    assign pop_req  = enable_i && rsp_done_i && !clear_i;
    assign pop      = pop_req && !empty;
    // A full FIFO still accepts a push when the oldest entry leaves in the same cycle.
    assign push     = push_req && (!full || pop);

    assign wr_entry.bytes = bytes_t'(ax_bytes_i);

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   ($bits(entry_t)),
        .DEPTH        (MaxPending),
        .dtype        (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear_i),
        .full_o  (full),
        .empty_o (empty),
        .usage_o (usage),
        .data_i  (wr_entry),
        .push_i  (push),
        .data_o  (rd_entry),
        .pop_i   (pop)
    );

    assign pending_o       = full ? pend_t'(MaxPending) : pend_t'(usage);
    assign limit_reached_o = (pending_o >= max_pending_i) || full;

    always_comb begin
        bytes_d   = bytes_q;
        err_d     = err_q;
        bytes_sum = {2'b00, bytes_q}
                  + (push ? {2'b00, wr_entry.bytes} : '0)
                  - (pop  ? {2'b00, rd_entry.bytes} : '0);
        if (clear_i) begin
            bytes_d = '0;
            err_d   = 1'b0;
        end else begin
            // Negative only after an earlier saturation lost track of the true sum.
            if (bytes_sum[BytesWidth+1]) begin
                bytes_d = '0;
            end else if (bytes_sum[BytesWidth]) begin
                bytes_d = '1;
                err_d   = 1'b1;
            end else begin
                bytes_d = bytes_sum[BytesWidth-1:0];
            end
            if ((push_req && !push) || (pop_req && empty)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bytes_q <= '0;
            err_q   <= 1'b0;
        end else begin
            bytes_q <= bytes_d;
            err_q   <= err_d;
        end
    end

    assign bytes_in_flight_o = bytes_q;
    assign error_o           = err_q;

`ifdef AXI_RT_RSP_LATENCY_EN
    rt_lat_t now_q, now_d, max_lat_q, max_lat_d, lat;

    assign wr_entry.stamp = now_q;
    assign lat            = now_q - rd_entry.stamp;

    always_comb begin
        now_d     = now_q + 1'b1;
        max_lat_d = max_lat_q;
        if (clear_i)                        max_lat_d = '0;
        else if (pop && (lat > max_lat_q))  max_lat_d = lat;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            now_q     <= '0;
            max_lat_q <= '0;
        end else begin
            now_q     <= now_d;
            max_lat_q <= max_lat_d;
        end
    end

    assign max_latency_o = max_lat_q;
`else
    assign max_latency_o = '0;
`endif

endmodule

// File: tb/tb_ax_rt_unit_rsp_tracker.sv
// Directed bench for ax_rt_unit_rsp_tracker with MaxPending=4, 8-bit accumulator, 10-bit request byte field.
module tb_ax_rt_unit_rsp_tracker;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic [9:0]  ax_bytes_i;
    logic        ax_happening_i;
    logic        rsp_done_i;
    logic [2:0]  max_pending_i;
    logic        clear_i;
    logic [2:0]  pending_o;
    logic [7:0]  bytes_in_flight_o;
    logic        limit_reached_o;
    logic        error_o;
    logic [31:0] max_latency_o;

    int n_cmp  = 0;
    int n_fail = 0;

    ax_rt_unit_rsp_tracker #(
        .MaxPending (4),
        .BytesWidth (8),
        .ax_bytes_t (logic [9:0])
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .enable_i          (enable_i),
        .ax_bytes_i        (ax_bytes_i),
        .ax_happening_i    (ax_happening_i),
        .rsp_done_i        (rsp_done_i),
        .max_pending_i     (max_pending_i),
        .clear_i           (clear_i),
        .pending_o         (pending_o),
        .bytes_in_flight_o (bytes_in_flight_o),
        .limit_reached_o   (limit_reached_o),
        .error_o           (error_o),
        .max_latency_o     (max_latency_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] b);
        ax_bytes_i     = b;
        ax_happening_i = 1'b1;
        tick();
        ax_happening_i = 1'b0;
    endtask

    task automatic done();
        rsp_done_i = 1'b1;
        tick();
        rsp_done_i = 1'b0;
    endtask

    initial begin
        logic [31:0] lat_exp;
`ifdef AXI_RT_RSP_LATENCY_EN
        lat_exp = 32'd17;
`else
        lat_exp = 32'd0;
`endif
        rst_ni = 1'b0; enable_i = 1'b0; ax_bytes_i = '0; ax_happening_i = 1'b0;
        rsp_done_i = 1'b0; max_pending_i = 3'd4; clear_i = 1'b0;
        repeat (3) tick();
        chk("rst_pending", 32'(pending_o), 0);
        chk("rst_bytes", 32'(bytes_in_flight_o), 0);
        chk("rst_error", 32'(error_o), 0);
        chk("rst_latency", max_latency_o, 0);
        chk("rst_limit", 32'(limit_reached_o), 0);
        max_pending_i = 3'd0; #1;
        chk("limit_zero_blocks", 32'(limit_reached_o), 1);
        max_pending_i = 3'd4;
        rst_ni = 1'b1; enable_i = 1'b1;

        push(10'd16);
        chk("push1_pending", 32'(pending_o), 1);
        chk("push1_bytes", 32'(bytes_in_flight_o), 16);
        push(10'd32);
        chk("push2_bytes", 32'(bytes_in_flight_o), 48);
        max_pending_i = 3'd2; #1;
        chk("limit_lowered", 32'(limit_reached_o), 1);
        max_pending_i = 3'd3; #1;
        chk("limit_raised", 32'(limit_reached_o), 0);
        max_pending_i = 3'd4;
        push(10'd64);
        push(10'h180);
        chk("fill_pending", 32'(pending_o), 4);
        chk("fill_bytes_trunc", 32'(bytes_in_flight_o), 240);
        chk("fill_limit", 32'(limit_reached_o), 1);
        max_pending_i = 3'd7; #1;
        chk("limit_storage_full", 32'(limit_reached_o), 1);
        max_pending_i = 3'd4;

        rsp_done_i = 1'b1;
        push(10'd8);
        rsp_done_i = 1'b0;
        chk("swap_pending", 32'(pending_o), 4);
        chk("swap_bytes", 32'(bytes_in_flight_o), 232);
        chk("swap_error", 32'(error_o), 0);

        push(10'd1);
        chk("overflow_error", 32'(error_o), 1);
        chk("overflow_pending", 32'(pending_o), 4);
        chk("overflow_bytes", 32'(bytes_in_flight_o), 232);

        clear_i = 1'b1; rsp_done_i = 1'b1;
        push(10'd9);
        clear_i = 1'b0; rsp_done_i = 1'b0;
        chk("clear_pending", 32'(pending_o), 0);
        chk("clear_bytes", 32'(bytes_in_flight_o), 0);
        chk("clear_error", 32'(error_o), 0);
        chk("clear_limit", 32'(limit_reached_o), 0);

        done();
        chk("underflow_error", 32'(error_o), 1);
        chk("underflow_pending", 32'(pending_o), 0);
        chk("underflow_bytes", 32'(bytes_in_flight_o), 0);
        tick();
        chk("error_sticky", 32'(error_o), 1);
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        chk("error_cleared", 32'(error_o), 0);

        enable_i = 1'b0;
        push(10'd5);
        chk("disabled_pending", 32'(pending_o), 0);
        chk("disabled_bytes", 32'(bytes_in_flight_o), 0);
        enable_i = 1'b1;

        push(10'd200);
        push(10'd100);
        chk("sat_bytes", 32'(bytes_in_flight_o), 255);
        chk("sat_error", 32'(error_o), 1);
        chk("sat_pending", 32'(pending_o), 2);
        clear_i = 1'b1; tick(); clear_i = 1'b0;

        push(10'd1);
        repeat (16) tick();
        done();
        chk("latency_17", max_latency_o, lat_exp);
        push(10'd1);
        repeat (4) tick();
        done();
        chk("latency_keeps_max", max_latency_o, lat_exp);
        chk("latency_pending", 32'(pending_o), 0);
        chk("latency_error", 32'(error_o), 0);

        push(10'd3);
        push(10'd4);
        chk("pre_reset_pending", 32'(pending_o), 2);
        chk("pre_reset_bytes", 32'(bytes_in_flight_o), 7);
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;
        chk("midrst_pending", 32'(pending_o), 0);
        chk("midrst_latency", max_latency_o, 0);
        done();
        chk("stale_rsp_error", 32'(error_o), 1);
        chk("stale_rsp_pending", 32'(pending_o), 0);
        chk("stale_rsp_bytes", 32'(bytes_in_flight_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
